// File: rtl/lite_cmd_master_if.sv
// Command/response port plus aw/w/ar/r lite bus bundle for lite_cmd_master.
// master: the command master's view; slave: the environment's view.
interface lite_cmd_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic [STRB_WIDTH-1:0] cmd_wstrb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_write;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_timeout;

   logic                  awvalid;
   logic                  awready;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  wvalid;
   logic                  wready;
   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  arvalid;
   logic                  arready;
   logic [ADDR_WIDTH-1:0] araddr;
   logic                  rvalid;
   logic                  rready;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      output cmd_ready,
      output rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
      input  rsp_ready,
      output awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
      input  awready, wready, arready, rvalid, rdata
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
      input  cmd_ready,
      input  rsp_valid, rsp_write, rsp_rdata, rsp_timeout,
      output rsp_ready,
      input  awvalid, awaddr, wvalid, wdata, wstrb, arvalid, araddr, rready,
      output awready, wready, arready, rvalid, rdata
   );
endinterface

// File: rtl/lite_cmd_master.sv
// Single-outstanding command master driving a lite aw/w/ar/r bus (no B channel),
// returning one response per command with a timeout flag for stalled slaves.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WRITE   | awvalid/wvalid outstanding, each cleared by its own handshake
// RD_ADDR | arvalid outstanding
// RD_DATA | rready high, waiting for rvalid
// RESP    | rsp_valid held until rsp_ready
module lite_cmd_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic clk,
   input  logic rst,
   lite_cmd_master_if.master bus
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int CNT_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
      (TIMEOUT_CYCLES > 0) ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_DATA, RESP} state_t;

   state_t                state, state_n;
   logic                  awvalid, awvalid_n, wvalid, wvalid_n;
   logic                  arvalid, arvalid_n, rready, rready_n;
   logic                  rsp_valid, rsp_valid_n, rsp_write, rsp_write_n;
   logic                  rsp_timeout, rsp_timeout_n;
   logic [DATA_WIDTH-1:0] rsp_rdata, rsp_rdata_n, wdata, wdata_n;
   logic [STRB_WIDTH-1:0] wstrb, wstrb_n;
   logic [ADDR_WIDTH-1:0] awaddr, awaddr_n, araddr, araddr_n;
   logic [CNT_WIDTH-1:0]  cnt, cnt_n, cnt_dec;
   logic                  expire;

   // Down-counter saturates at zero so a late ar handshake still times out in RD_DATA.
   assign cnt_dec = (cnt != '0) ? cnt - CNT_WIDTH'(1) : cnt;
   assign expire  = (TIMEOUT_CYCLES != 0) && (cnt == '0);

   always_comb begin
      state_n       = state;
      awvalid_n     = awvalid;
      wvalid_n      = wvalid;
      arvalid_n     = arvalid;
      rready_n      = rready;
      rsp_valid_n   = rsp_valid;
      rsp_write_n   = rsp_write;
      rsp_timeout_n = rsp_timeout;
      rsp_rdata_n   = rsp_rdata;
      wdata_n       = wdata;
      wstrb_n       = wstrb;
      awaddr_n      = awaddr;
      araddr_n      = araddr;
      cnt_n         = cnt;
      case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               rsp_write_n = bus.cmd_write;
               cnt_n       = CNT_LOAD;
               if (bus.cmd_write) begin
                  awaddr_n  = bus.cmd_addr;
                  wdata_n   = bus.cmd_wdata;
                  wstrb_n   = bus.cmd_wstrb;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
                  state_n   = WRITE;
               end else begin
                  araddr_n  = bus.cmd_addr;
                  arvalid_n = 1'b1;
                  state_n   = RD_ADDR;
               end
            end
         end
         WRITE: begin
            awvalid_n = awvalid && !bus.awready;
            wvalid_n  = wvalid && !bus.wready;
            cnt_n     = cnt_dec;
            if (!awvalid_n && !wvalid_n) begin
               rsp_valid_n   = 1'b1;
               rsp_rdata_n   = '0;
               rsp_timeout_n = 1'b0;
               state_n       = RESP;
            end else if (expire) begin
               awvalid_n     = 1'b0;
               wvalid_n      = 1'b0;
               rsp_valid_n   = 1'b1;
               rsp_rdata_n   = '0;
               rsp_timeout_n = 1'b1;
               state_n       = RESP;
            end
         end
         RD_ADDR: begin
            cnt_n = cnt_dec;
            if (bus.arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = RD_DATA;
            end else if (expire) begin
               arvalid_n     = 1'b0;
               rsp_valid_n   = 1'b1;
               rsp_rdata_n   = '0;
               rsp_timeout_n = 1'b1;
               state_n       = RESP;
            end
         end
         RD_DATA: begin
            cnt_n = cnt_dec;
            if (bus.rvalid || expire) begin
               rready_n      = 1'b0;
               rsp_valid_n   = 1'b1;
               rsp_rdata_n   = bus.rvalid ? bus.rdata : '0;
               rsp_timeout_n = !bus.rvalid;
               state_n       = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         arvalid     <= 1'b0;
         rready      <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_write   <= 1'b0;
         rsp_timeout <= 1'b0;
         rsp_rdata   <= '0;
         wdata       <= '0;
         wstrb       <= '0;
         awaddr      <= '0;
         araddr      <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_n;
         awvalid     <= awvalid_n;
         wvalid      <= wvalid_n;
         arvalid     <= arvalid_n;
         rready      <= rready_n;
         rsp_valid   <= rsp_valid_n;
         rsp_write   <= rsp_write_n;
         rsp_timeout <= rsp_timeout_n;
         rsp_rdata   <= rsp_rdata_n;
         wdata       <= wdata_n;
         wstrb       <= wstrb_n;
         awaddr      <= awaddr_n;
         araddr      <= araddr_n;
         cnt         <= cnt_n;
      end
   end

   assign bus.cmd_ready   = (state == IDLE);
   assign bus.awvalid     = awvalid;
   assign bus.awaddr      = awaddr;
   assign bus.wvalid      = wvalid;
   assign bus.wdata       = wdata;
   assign bus.wstrb       = wstrb;
   assign bus.arvalid     = arvalid;
   assign bus.araddr      = araddr;
   assign bus.rready      = rready;
   assign bus.rsp_valid   = rsp_valid;
   assign bus.rsp_write   = rsp_write;
   assign bus.rsp_rdata   = rsp_rdata;
   assign bus.rsp_timeout = rsp_timeout;
endmodule

// File: tb/tb_lite_cmd_master.sv
// Scoreboarded random bench for lite_cmd_master against a delay-configurable
// register slave; expected responses and latencies come from a word-array model.
module tb_lite_cmd_master;
   localparam int DW = 32;
   localparam int AW = 12;
   localparam int SW = DW / 8;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   lite_cmd_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   lite_cmd_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic          write;
      logic [DW-1:0] rdata;
      logic          timeout;
      int            cyc;
   } exp_t;

   exp_t          exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] ref_mem[16];
   logic [DW-1:0] slv_mem[16];

   int cfg_aw, cfg_w, cfg_ar, cfg_r;
   bit cfg_st_wr, cfg_st_ar, cfg_st_r;
   int txn_seq = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Register slave: each ready/rvalid rises after a per-transaction number of waiting cycles.
   initial begin : slave
      int            seen_seq, aw_wait, w_wait, ar_wait, r_wait;
      bit            st_wr, st_ar, st_r, aw_have, w_have, r_pend;
      logic [AW-1:0] aw_a;
      logic [DW-1:0] w_d, r_d;
      logic [SW-1:0] w_s;
      seen_seq = 0; aw_wait = 0; w_wait = 0; ar_wait = 0; r_wait = 0;
      st_wr = 0; st_ar = 0; st_r = 0; aw_have = 0; w_have = 0; r_pend = 0;
      aw_a = '0; w_d = '0; r_d = '0; w_s = '0;
      for (int i = 0; i < 16; i++) slv_mem[i] = '0;
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.rvalid = 1'b0; bus.rdata = '0;
      forever begin
         @(posedge clk);
         if (rst) begin
            aw_have = 0; w_have = 0; r_pend = 0;
         end else begin
            if (bus.awvalid && bus.awready) begin aw_a = bus.awaddr; aw_have = 1; end
            if (bus.wvalid && bus.wready) begin w_d = bus.wdata; w_s = bus.wstrb; w_have = 1; end
            if (aw_have && w_have) begin
               for (int b = 0; b < SW; b++)
                  if (w_s[b]) slv_mem[aw_a[5:2]][8*b +: 8] = w_d[8*b +: 8];
               aw_have = 0; w_have = 0;
            end
            if (bus.arvalid && bus.arready) begin r_d = slv_mem[bus.araddr[5:2]]; r_pend = 1; end
            if (bus.rvalid && bus.rready) r_pend = 0;
         end
         @(negedge clk);
         if (txn_seq != seen_seq) begin
            seen_seq = txn_seq;
            aw_wait = cfg_aw; w_wait = cfg_w; ar_wait = cfg_ar; r_wait = cfg_r;
            st_wr = cfg_st_wr; st_ar = cfg_st_ar; st_r = cfg_st_r;
            aw_have = 0; w_have = 0; r_pend = 0;
         end
         if (!bus.awvalid) bus.awready = 1'b0;
         else if (!bus.awready && !st_wr) begin
            if (aw_wait == 0) bus.awready = 1'b1; else aw_wait--;
         end
         if (!bus.wvalid) bus.wready = 1'b0;
         else if (!bus.wready && !st_wr) begin
            if (w_wait == 0) bus.wready = 1'b1; else w_wait--;
         end
         if (!bus.arvalid) bus.arready = 1'b0;
         else if (!bus.arready && !st_ar) begin
            if (ar_wait == 0) bus.arready = 1'b1; else ar_wait--;
         end
         if (!r_pend) bus.rvalid = 1'b0;
         else if (!bus.rvalid && !st_r) begin
            if (r_wait == 0) begin bus.rvalid = 1'b1; bus.rdata = r_d; end
            else r_wait--;
         end
      end
   end

   // Monitor: pops one expectation per response and checks it every cycle it is held.
   initial begin : monitor
      exp_t cur;
      bit   seen, hs;
      int   nresp, hold;
      seen = 0; hs = 0; nresp = 0; hold = 0;
      cur = '{write: 1'b0, rdata: '0, timeout: 1'b0, cyc: 0};
      bus.rsp_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (hs) seen = 0;
         hs = 0;
         if (rst) begin
            seen = 0; hold = 0; bus.rsp_ready = 1'b0;
            continue;
         end
         if (bus.rsp_valid) begin
            if (!seen) begin
               seen = 1;
               nresp++;
               if (nresp % 5 == 0) hold = 10;
               if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
               else begin
                  cur = exp_q.pop_front();
                  check("rsp_latency", cyc, cur.cyc);
               end
            end
            check("cmd_ready_in_rsp", bus.cmd_ready, 0);
            check("bus_idle_in_rsp", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
            check("rsp_write", bus.rsp_write, cur.write);
            check("rsp_rdata", bus.rsp_rdata, cur.rdata);
            check("rsp_timeout", bus.rsp_timeout, cur.timeout);
            if (hold > 0) begin
               bus.rsp_ready = 1'b0;
               hold--;
            end else bus.rsp_ready = ($urandom_range(0, 3) != 0);
            hs = bus.rsp_ready;
         end else bus.rsp_ready = 1'(($urandom_range(0, 1)));
      end
   end

   task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input int daw, input int dw, input int dar,
                        input int dr, input bit st_wr, input bit st_ar, input bit st_r,
                        input bit expect_rsp);
      exp_t e;
      int   waited;
      waited = 0;
      @(negedge clk);
      while (!bus.cmd_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.cmd_ready) begin
         check("cmd_ready_wait", 0, 1);
         return;
      end
      cfg_aw = daw; cfg_w = dw; cfg_ar = dar; cfg_r = dr;
      cfg_st_wr = st_wr; cfg_st_ar = st_ar; cfg_st_r = st_r;
      txn_seq++;
      bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a;
      bus.cmd_wdata = d; bus.cmd_wstrb = s;
      e.write   = wr;
      e.timeout = wr ? st_wr : (st_ar || st_r);
      e.rdata   = '0;
      if (e.timeout) e.cyc = cyc + TO + 1;
      else if (wr) begin
         e.cyc = cyc + 2 + ((daw > dw) ? daw : dw);
         for (int b = 0; b < SW; b++)
            if (s[b]) ref_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end else begin
         e.cyc   = cyc + 3 + dar + dr;
         e.rdata = ref_mem[a[5:2]];
      end
      if (expect_rsp) exp_q.push_back(e);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_wdata = DW'($urandom);
      check("cmd_ready_busy", bus.cmd_ready, 0);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1);
   end

   initial begin : stimulus
      int   waited;
      logic wr;
      for (int i = 0; i < 16; i++) ref_mem[i] = '0;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
      bus.cmd_wdata = '0; bus.cmd_wstrb = '0;
      cfg_aw = 0; cfg_w = 0; cfg_ar = 0; cfg_r = 0;
      cfg_st_wr = 0; cfg_st_ar = 0; cfg_st_r = 0;
      repeat (3) @(negedge clk);
      check("rst_bus_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      check("rst_rsp", {bus.rsp_valid, bus.rsp_write, bus.rsp_timeout}, 0);
      check("rst_rsp_rdata", bus.rsp_rdata, 0);
      check("rst_addrs", {bus.awaddr, bus.araddr}, 0);
      check("rst_wdata_wstrb", {bus.wdata, bus.wstrb}, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      rst = 1'b0;

      issue(1, 12'h000, 32'h0000_00A5, 4'hF, 1, 1, 0, 0, 0, 0, 0, 1);
      issue(0, 12'h000, '0, '0, 0, 0, 1, 0, 0, 0, 0, 1);
      issue(1, 12'h004, 32'h1234_5678, 4'h5, 1, 5, 0, 0, 0, 0, 0, 1);
      issue(1, 12'h008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 1, 0, 0, 1);
      issue(0, 12'h004, '0, '0, 0, 0, 2, 0, 0, 0, 1, 1);
      issue(0, 12'h000, '0, '0, 0, 0, 0, 0, 0, 1, 0, 1);
      issue(0, 12'h004, '0, '0, 0, 0, 0, 3, 0, 0, 0, 1);

      for (int n = 0; n < 80; n++) begin
         wr = 1'($urandom_range(0, 1));
         issue(wr, AW'($urandom), DW'($urandom), SW'($urandom),
               $urandom_range(0, 4), $urandom_range(0, 4),
               $urandom_range(0, 4), $urandom_range(0, 4),
               wr && ($urandom_range(0, 9) == 0),
               !wr && ($urandom_range(0, 14) == 0),
               !wr && ($urandom_range(0, 14) == 0), 1);
      end

      // Abandon a read stuck in RD_ADDR with reset; no response may follow.
      issue(0, 12'h000, '0, '0, 0, 0, 0, 0, 0, 1, 0, 0);
      repeat (2) @(negedge clk);
      check("arvalid_before_rst", bus.arvalid, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.rready}, 0);
      check("rst_mid_rsp_valid", bus.rsp_valid, 0);
      check("rst_mid_cmd_ready", bus.cmd_ready, 1);
      issue(0, 12'h000, '0, '0, 0, 0, 1, 0, 0, 0, 0, 1);
      issue(1, 12'h03C, 32'hCAFE_F00D, 4'hC, 2, 0, 0, 0, 0, 0, 0, 1);
      issue(0, 12'h03C, '0, '0, 0, 0, 0, 1, 0, 0, 0, 1);

      waited = 0;
      while ((exp_q.size() != 0 || !bus.cmd_ready) && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
